// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM family: state encoding,
// read-during-write mode constants and a byte-count helper.
package ram_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int byteCount(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Depth-N data+valid register pipeline with synchronous flush; data only
// advances alongside a valid so each stage holds its last word between reads.
module ram_rd_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (STAGES < 1) begin : gBadStages
    $error("ram_rd_pipe: STAGES must be at least 1");
  end

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  always_ff @(posedge clk) begin
    if (flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with per-byte write enables, 1/2-cycle read latency,
// selectable read-during-write result and a post-reset clear engine.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DEPTH          = 256,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    RDW_MODE       = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int NBYTES = byteCount(DATA_WIDTH);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : gBadWidth
    $error("ram_dp_be: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
    $error("ram_dp_be: READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : gBadDepth
    $error("ram_dp_be: DEPTH must be between 1 and 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic                  rdValid_q, rdValid_d;

  logic                  ready, wrInRange, rdInRange, wrFire, rdFire, collide;
  logic [IDX_W-1:0]      wrIdx, rdIdx;
  logic [DATA_WIDTH-1:0] oldWord, mergedWord, rdWord;

  // Requests are only honoured in READY and never on a reset edge.
  assign ready     = (state_q == ST_READY) && !rst;
  assign busy      = (state_q == ST_CLEAR);
  assign wrInRange = {1'b0, wr_addr} < DEPTH_EXT;
  assign rdInRange = {1'b0, rd_addr} < DEPTH_EXT;
  assign wrIdx     = wr_addr[IDX_W-1:0];
  assign rdIdx     = rd_addr[IDX_W-1:0];
  assign wrFire    = ready && wr_en && wrInRange;
  assign rdFire    = ready && rd_en;
  assign collide   = wrFire && rdInRange && (wr_addr == rd_addr);
  assign oldWord   = rdInRange ? mem[rdIdx] : '0;

  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) begin
        mergedWord[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  assign rdWord = (collide && RDW_MODE == RDW_NEW) ? mergedWord : oldWord;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == LAST_IDX) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end
  end

  assign rdData_d  = rdFire ? rdWord : rdData_q;
  assign rdValid_d = rdFire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q     <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

  // The array has no reset; the clear engine is the only way to initialise it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_CLEAR) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (wrFire) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) begin
          mem[wrIdx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : gLat2
    ram_rd_pipe #(
      .WIDTH  (DATA_WIDTH),
      .STAGES (1)
    ) uRdPipe (
      .clk     (clk),
      .flush_i (rst),
      .valid_i (rdValid_q),
      .data_i  (rdData_q),
      .valid_o (rd_valid),
      .data_o  (rd_data)
    );
  end else begin : gLat1
    assign rd_valid = rdValid_q;
    assign rd_data  = rdData_q;
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench: u0 is an 8-bit/16-deep/latency-1/old-data RAM, u1 a
// 32-bit/200-deep/latency-2/new-data RAM; both share clock, reset and request buses.
module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrEn = 1'b0;
  logic [7:0]  wrAddr = '0;
  logic [3:0]  wrBe = '0;
  logic [31:0] wrData = '0;
  logic        rdEn = 1'b0;
  logic [7:0]  rdAddr = '0;

  logic [7:0]  rdData0;
  logic        rdValid0, busy0;
  logic [31:0] rdData1;
  logic        rdValid1, busy1;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  ram_dp_be #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .READ_LATENCY(1),
    .RDW_MODE(0), .CLEAR_ON_RESET(1), .INIT_VALUE(8'hA5)
  ) u0 (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_be(wrBe[0:0]),
    .wr_data(wrData[7:0]), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData0),
    .rd_valid(rdValid0), .busy(busy0)
  );

  ram_dp_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(2),
    .RDW_MODE(1), .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)
  ) u1 (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_be(wrBe),
    .wr_data(wrData), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData1),
    .rd_valid(rdValid1), .busy(busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    wrEn = 1'b1; wrAddr = a; wrBe = be; wrData = d;
    step();
    wrEn = 1'b0;
  endtask

  // Issues one read (plus any write already set up) and checks both instances.
  task automatic readCheck(input string tag, input logic [7:0] a,
                           input logic [31:0] exp0, input logic [31:0] exp1);
    rdEn = 1'b1; rdAddr = a;
    step();
    rdEn = 1'b0; wrEn = 1'b0;
    checkOutput({tag, " u0 valid"}, {31'b0, rdValid0}, 32'd1);
    checkOutput({tag, " u0 data"}, {24'b0, rdData0}, exp0);
    checkOutput({tag, " u1 valid early"}, {31'b0, rdValid1}, 32'd0);
    step();
    checkOutput({tag, " u1 valid"}, {31'b0, rdValid1}, 32'd1);
    checkOutput({tag, " u1 data"}, rdData1, exp1);
    checkOutput({tag, " u0 valid pulse"}, {31'b0, rdValid0}, 32'd0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("reset u0 valid", {31'b0, rdValid0}, 32'd0);
    checkOutput("reset u0 data", {24'b0, rdData0}, 32'd0);
    checkOutput("reset u1 valid", {31'b0, rdValid1}, 32'd0);
    checkOutput("reset u1 data", rdData1, 32'd0);
    checkOutput("reset u0 busy", {31'b0, busy0}, 32'd1);
    checkOutput("reset u1 busy", {31'b0, busy1}, 32'd1);
  endtask

  // Counts busy cycles of each instance until both are idle (bounded).
  task automatic applyStimulus(input string tag, input bit withRequests);
    int n = 0, c0 = 0, c1 = 0, vc = 0;
    while ((busy0 || busy1) && n < 500) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (rdValid0 || rdValid1) vc++;
      wrEn = withRequests && n < 10; wrAddr = 8'd2; wrBe = 4'hF; wrData = 32'h77777777;
      rdEn = withRequests && n < 10; rdAddr = 8'd2;
      step();
      n++;
    end
    wrEn = 1'b0; rdEn = 1'b0;
    checkOutput({tag, " u0 busy cycles"}, c0, 32'd16);
    checkOutput({tag, " u1 busy cycles"}, c1, 32'd200);
    checkOutput({tag, " valid while busy"}, vc, 32'd0);
  endtask

  initial begin
    logic [31:0] v;

    // Clear, with requests that must be ignored while busy.
    applyReset();
    applyStimulus("clear", 1'b1);
    for (int a = 0; a < 16; a++) begin
      readCheck($sformatf("clear addr %0d", a), 8'(a), 32'hA5, 32'h0);
    end

    // Byte enables.
    doWrite(8'd3, 4'hF, 32'h11223344);
    doWrite(8'd3, 4'b0101, 32'hAABBCCDD);
    readCheck("byte enable", 8'd3, 32'hDD, 32'h11BB33DD);

    // Back-to-back reads: u1 valid must trail u0 by one cycle.
    for (int i = 0; i < 8; i++) begin
      doWrite(8'(i), 4'hF, 32'h01010101 * (i + 1));
    end
    for (int j = 0; j < 12; j++) begin
      rdEn = (j < 8); rdAddr = 8'(j);
      step();
      checkOutput($sformatf("burst %0d u0 valid", j), {31'b0, rdValid0}, (j < 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("burst %0d u1 valid", j), {31'b0, rdValid1},
                  (j >= 1 && j <= 8) ? 32'd1 : 32'd0);
      if (j < 8) checkOutput($sformatf("burst %0d u0 data", j), {24'b0, rdData0}, 32'(j + 1));
      if (j >= 1 && j <= 8) begin
        checkOutput($sformatf("burst %0d u1 data", j), rdData1, 32'h01010101 * j);
      end
    end
    rdEn = 1'b0;
    checkOutput("hold u0 data", {24'b0, rdData0}, 32'h08);
    checkOutput("hold u1 data", rdData1, 32'h08080808);

    // Read-during-write collisions.
    doWrite(8'd5, 4'hF, 32'h00000012);
    wrEn = 1'b1; wrAddr = 8'd5; wrBe = 4'hF; wrData = 32'h00000034;
    readCheck("collide full", 8'd5, 32'h12, 32'h34);
    readCheck("after collide", 8'd5, 32'h34, 32'h34);
    doWrite(8'd6, 4'hF, 32'h11223344);
    wrEn = 1'b1; wrAddr = 8'd6; wrBe = 4'b1010; wrData = 32'hAABBCCDD;
    readCheck("collide merge", 8'd6, 32'h44, 32'hAA22CC44);
    readCheck("after merge", 8'd6, 32'h44, 32'hAA22CC44);

    // Out of range for both depths; must not alias onto addr 0.
    doWrite(8'hF0, 4'hF, 32'hDEADBEEF);
    readCheck("out of range", 8'hF0, 32'h0, 32'h0);
    readCheck("no alias", 8'd0, 32'h01, 32'h01010101);

    // Reset with a read in flight, then again part-way through the clear.
    rdEn = 1'b1; rdAddr = 8'd1;
    step();
    rdEn = 1'b0;
    checkOutput("inflight u0 data", {24'b0, rdData0}, 32'h02);
    applyReset();
    for (int k = 0; k < 7; k++) step();
    v = {31'b0, busy0};
    checkOutput("mid clear busy", v, 32'd1);
    applyReset();
    applyStimulus("restart", 1'b0);
    readCheck("after restart", 8'd1, 32'hA5, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
